// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Purpose : bundles every non-clock/reset signal between the fetch/execute
//           sequencer and its surroundings (PC register, instruction memory,
//           datapath control).
// Modports:
//   master - the sequencer side: drives pc_load/pc_target_addr, imem_req/
//            imem_addr, ir_load, exec_en, halted, trap, state_dbg; samples
//            run, pc_current_address, imem_ack, exec_done, branch_taken,
//            branch_target, halt_req.
//   slave  - the environment side, directions mirrored.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              run;
    logic [ADDR_W-1:0] pc_current_address;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target_addr;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic              ir_load;
    logic              exec_en;
    logic              exec_done;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              halt_req;
    logic              halted;
    logic              trap;
    logic [2:0]        state_dbg;

    modport master (
        input  run, pc_current_address, imem_ack, exec_done,
               branch_taken, branch_target, halt_req,
        output pc_load, pc_target_addr, imem_req, imem_addr, ir_load,
               exec_en, halted, trap, state_dbg
    );

    modport slave (
        output run, pc_current_address, imem_ack, exec_done,
               branch_taken, branch_target, halt_req,
        input  pc_load, pc_target_addr, imem_req, imem_addr, ir_load,
               exec_en, halted, trap, state_dbg
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Purpose : multi-cycle fetch/execute controller for the program counter.
//           Boots the PC to RESET_VEC, requests each instruction from the
//           instruction memory, strobes the IR and the execute stage, then
//           loads the next PC (sequential, branch target, or nothing on halt).
//           A fetch that waits MEM_TIMEOUT cycles without an ack traps.
// Ports   :
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (returns to IDLE, all outputs 0)
//   bus    - pc_sequencer_if.master carrying run, PC, imem and exec signals
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              STEP        = 4,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.master  bus
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BOOT   = 3'd1,
        S_FETCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_fetch_cnt;
    logic              r_exec_started;
    logic              r_branch_taken;
    logic [ADDR_W-1:0] r_branch_target;

    logic              w_fetch_last;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_taken_pc;

    // r_fetch_cnt holds the number of FETCH cycles already spent, so the
    // current cycle is the last allowed one when it equals MEM_TIMEOUT-1.
    assign w_fetch_last = (r_fetch_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign w_seq_pc     = bus.pc_current_address + ADDR_W'(STEP);
    assign w_taken_pc   = r_branch_target & ~ADDR_W'(3);

    // State register, fetch-timeout counter, first-EXEC-cycle marker and the
    // branch decision captured when the datapath reports completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_fetch_cnt     <= '0;
            r_exec_started  <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH && w_next_state == S_FETCH) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end else begin
                r_fetch_cnt <= '0;
            end
            // Set after the first EXEC cycle so exec_en is a single pulse
            // even when exec_done takes many cycles.
            r_exec_started <= (r_state == S_EXEC);
            if (r_state == S_EXEC && bus.exec_done) begin
                r_branch_taken  <= bus.branch_taken;
                r_branch_target <= bus.branch_target;
            end
        end
    end

    // Next-state and output decode; outputs depend on the state plus the
    // handshake inputs so the IR strobe coincides with the memory ack.
    always_comb begin
        w_next_state       = r_state;
        bus.pc_load        = 1'b0;
        bus.pc_target_addr = '0;
        bus.imem_req       = 1'b0;
        bus.imem_addr      = '0;
        bus.ir_load        = 1'b0;
        bus.exec_en        = 1'b0;
        bus.halted         = 1'b0;
        bus.trap           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_next_state = S_BOOT;
                end
            end
            S_BOOT: begin
                bus.pc_load        = 1'b1;
                bus.pc_target_addr = RESET_VEC;
                w_next_state       = S_FETCH;
            end
            S_FETCH: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = bus.pc_current_address;
                if (bus.imem_ack) begin
                    bus.ir_load  = 1'b1;
                    w_next_state = S_EXEC;
                end else if (w_fetch_last) begin
                    w_next_state = S_TRAP;
                end
            end
            S_EXEC: begin
                bus.exec_en = !r_exec_started;
                if (bus.exec_done) begin
                    w_next_state = bus.halt_req ? S_HALT : S_UPDATE;
                end
            end
            S_UPDATE: begin
                bus.pc_load        = 1'b1;
                bus.pc_target_addr = r_branch_taken ? w_taken_pc : w_seq_pc;
                w_next_state       = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            S_TRAP: begin
                bus.trap = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Purpose : directed bench for pc_sequencer. A simple PC register lives in the
//           bench and loads whenever the sequencer strobes pc_load. Every cycle
//           the outputs are compared with a behavioural model of the fetch/
//           execute rules; scripted scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int PH_IDLE   = 0;
    localparam int PH_BOOT   = 1;
    localparam int PH_FETCH  = 2;
    localparam int PH_EXEC   = 3;
    localparam int PH_UPDATE = 4;
    localparam int PH_HALT   = 5;
    localparam int PH_TRAP   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pcReg = 8'h00;
    logic       pcOverrideEn = 1'b0;
    logic [7:0] pcOverrideVal = 8'h00;

    int errors = 0;
    int checks = 0;

    // Model state: phase follows the published state codes.
    int       mPh = PH_IDLE;
    int       mFetchN = 0;
    bit       mFirst = 1'b0;
    bit       mTaken = 1'b0;
    int       mTarget = 0;
    int       cycleNo = 0;
    int       loadCycle[$];
    int       loadTarget[$];

    pc_sequencer_if #(.ADDR_W(8)) sif();

    pc_sequencer #(
        .ADDR_W(8), .RESET_VEC(8'h00), .STEP(4), .MEM_TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.master)
    );

    assign sif.pc_current_address = pcReg;

    always #5 clk = ~clk;

    // Stand-in for the real PC register; the override lets a test plant an
    // arbitrary PC value during a stalled fetch.
    always @(posedge clk) begin
        if (pcOverrideEn) pcReg <= pcOverrideVal;
        else if (sif.pc_load) pcReg <= sif.pc_target_addr;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit run, input bit ack, input bit done,
                                 input bit taken, input logic [7:0] target, input bit halt);
        sif.run           = run;
        sif.imem_ack      = ack;
        sif.exec_done     = done;
        sif.branch_taken  = taken;
        sif.branch_target = target;
        sif.halt_req      = halt;
        #2;
    endtask

    // Expected outputs for the present cycle from the behavioural rules, then
    // advance the model to what the next clock edge must produce.
    task automatic modelCompare();
        bit eLoad, eIr, eReq, eEx, eHalt, eTrap;
        int eTgt, eAddr, nPh;
        eLoad = 0; eIr = 0; eReq = 0; eEx = 0; eHalt = 0; eTrap = 0;
        eTgt = 0; eAddr = 0; nPh = mPh;
        if (!rst_n) begin
            mPh = PH_IDLE; mFetchN = 0; mFirst = 0; mTaken = 0; mTarget = 0;
            nPh = PH_IDLE;
        end else begin
            case (mPh)
                PH_IDLE:   nPh = sif.run ? PH_BOOT : PH_IDLE;
                PH_BOOT: begin eLoad = 1; eTgt = 0; nPh = PH_FETCH; end
                PH_FETCH: begin
                    eReq = 1; eAddr = int'(pcReg);
                    mFetchN++;
                    if (sif.imem_ack) begin
                        eIr = 1; nPh = PH_EXEC; mFetchN = 0; mFirst = 1;
                    end else if (mFetchN == 15) begin
                        nPh = PH_TRAP; mFetchN = 0;
                    end
                end
                PH_EXEC: begin
                    eEx = mFirst; mFirst = 0;
                    if (sif.exec_done) begin
                        mTaken  = sif.branch_taken;
                        mTarget = (int'(sif.branch_target) / 4) * 4;
                        nPh = sif.halt_req ? PH_HALT : PH_UPDATE;
                    end
                end
                PH_UPDATE: begin
                    eLoad = 1;
                    eTgt  = mTaken ? mTarget : (int'(pcReg) + 4) % 256;
                    nPh   = sif.run ? PH_FETCH : PH_IDLE;
                end
                PH_HALT: eHalt = 1;
                PH_TRAP: eTrap = 1;
                default: nPh = PH_IDLE;
            endcase
        end
        checkOutput("state_dbg", 32'(sif.state_dbg), 32'(mPh));
        checkOutput("pc_load", 32'(sif.pc_load), 32'(eLoad));
        checkOutput("pc_target_addr", 32'(sif.pc_target_addr), 32'(eTgt));
        checkOutput("imem_req", 32'(sif.imem_req), 32'(eReq));
        checkOutput("imem_addr", 32'(sif.imem_addr), 32'(eAddr));
        checkOutput("ir_load", 32'(sif.ir_load), 32'(eIr));
        checkOutput("exec_en", 32'(sif.exec_en), 32'(eEx));
        checkOutput("halted", 32'(sif.halted), 32'(eHalt));
        checkOutput("trap", 32'(sif.trap), 32'(eTrap));
        if (rst_n && sif.pc_load === 1'b1) begin
            loadCycle.push_back(cycleNo);
            loadTarget.push_back(int'(sif.pc_target_addr));
        end
        cycleNo++;
        mPh = nPh;
    endtask

    // One clock: model check mid-cycle, then land just after the next edge.
    task automatic step();
        @(negedge clk);
        modelCompare();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 8'h00, 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mark;
        sif.run = 0; sif.imem_ack = 0; sif.exec_done = 0;
        sif.branch_taken = 0; sif.branch_target = 8'h00; sif.halt_req = 0;
        @(posedge clk); #1;

        // Reset state
        #1;
        checkOutput("reset state_dbg", 32'(sif.state_dbg), 32'd0);
        checkOutput("reset pc_load", 32'(sif.pc_load), 32'd0);
        checkOutput("reset imem_req", 32'(sif.imem_req), 32'd0);
        doReset();

        // 1: sequential run, immediate ack and done
        mark = loadCycle.size();
        applyStimulus(1, 1, 1, 0, 8'h00, 0);
        repeat (8) step();
        checkOutput("t1 load count", 32'(loadCycle.size() - mark), 32'd3);
        if (loadCycle.size() >= mark + 3) begin
            checkOutput("t1 load0", 32'(loadTarget[mark]), 32'h00);
            checkOutput("t1 load1", 32'(loadTarget[mark+1]), 32'h04);
            checkOutput("t1 load2", 32'(loadTarget[mark+2]), 32'h08);
            checkOutput("t1 period a", 32'(loadCycle[mark+1] - loadCycle[mark]), 32'd3);
            checkOutput("t1 period b", 32'(loadCycle[mark+2] - loadCycle[mark+1]), 32'd3);
        end

        // 2: PC wrap from 0xFC
        doReset();
        applyStimulus(1, 0, 1, 0, 8'h00, 0);
        step();
        step();
        pcOverrideVal = 8'hFC; pcOverrideEn = 1'b1;
        step();
        pcOverrideEn = 1'b0;
        applyStimulus(1, 1, 1, 0, 8'h00, 0);
        checkOutput("t2 fetch addr FC", 32'(sif.imem_addr), 32'hFC);
        step();
        step();
        checkOutput("t2 wrap pc_load", 32'(sif.pc_load), 32'd1);
        checkOutput("t2 wrap target", 32'(sif.pc_target_addr), 32'h00);
        step();
        checkOutput("t2 next fetch addr", 32'(sif.imem_addr), 32'h00);
        checkOutput("t2 next imem_req", 32'(sif.imem_req), 32'd1);

        // 3: taken branch to 0x33 aligns to 0x30, then run drops mid-instruction
        doReset();
        applyStimulus(1, 1, 1, 1, 8'h33, 0);
        repeat (4) step();
        checkOutput("t3 branch target", 32'(sif.pc_target_addr), 32'h30);
        step();
        checkOutput("t3 fetch at target", 32'(sif.imem_addr), 32'h30);
        applyStimulus(0, 1, 1, 0, 8'h00, 0);
        step();
        step();
        checkOutput("t3 update after run=0", 32'(sif.pc_target_addr), 32'h34);
        step();
        checkOutput("t3 idle after run=0", 32'(sif.state_dbg), 32'd0);
        applyStimulus(1, 1, 1, 0, 8'h00, 0);
        step();
        checkOutput("t3 reboot target", 32'(sif.pc_target_addr), 32'h00);
        checkOutput("t3 reboot load", 32'(sif.pc_load), 32'd1);

        // 4: halt is sticky through run toggling
        doReset();
        applyStimulus(1, 1, 1, 0, 8'h00, 1);
        repeat (4) step();
        checkOutput("t4 halted", 32'(sif.halted), 32'd1);
        mark = loadCycle.size();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(bit'(i % 2), 1, 1, 0, 8'h00, 1);
            step();
        end
        checkOutput("t4 halted held", 32'(sif.halted), 32'd1);
        checkOutput("t4 state halt", 32'(sif.state_dbg), 32'd5);
        checkOutput("t4 no pc_load", 32'(loadCycle.size() - mark), 32'd0);

        // 5a: ack on the last allowed fetch cycle is accepted
        doReset();
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        repeat (16) step();
        applyStimulus(1, 1, 0, 0, 8'h00, 0);
        checkOutput("t5 ack cycle15 ir_load", 32'(sif.ir_load), 32'd1);
        step();
        checkOutput("t5 exec_en", 32'(sif.exec_en), 32'd1);
        applyStimulus(1, 0, 1, 0, 8'h00, 0);
        step();
        step();

        // 5b: no ack at all traps after cycle 15
        doReset();
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        repeat (16) step();
        checkOutput("t5 cycle15 still fetching", 32'(sif.imem_req), 32'd1);
        step();
        checkOutput("t5 trap", 32'(sif.trap), 32'd1);
        checkOutput("t5 trap state", 32'(sif.state_dbg), 32'd6);
        applyStimulus(1, 1, 1, 0, 8'h00, 0);
        repeat (5) step();
        checkOutput("t5 trap sticky", 32'(sif.trap), 32'd1);
        checkOutput("t5 trap imem_req", 32'(sif.imem_req), 32'd0);

        // 6: reset during EXEC with exec_done pending
        doReset();
        applyStimulus(1, 1, 0, 0, 8'h00, 0);
        repeat (3) step();
        checkOutput("t6 in exec", 32'(sif.exec_en), 32'd1);
        applyStimulus(1, 1, 1, 0, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async state", 32'(sif.state_dbg), 32'd0);
        checkOutput("t6 async exec_en", 32'(sif.exec_en), 32'd0);
        checkOutput("t6 async pc_load", 32'(sif.pc_load), 32'd0);
        mark = loadCycle.size();
        step();
        step();
        checkOutput("t6 no load in reset", 32'(loadCycle.size() - mark), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("t6 boot load", 32'(sif.pc_load), 32'd1);
        checkOutput("t6 boot target", 32'(sif.pc_target_addr), 32'h00);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
